// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I instruction decode with WB bypass, load-use stall and ID/EX register
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  input  logic        flush_e,
  output logic [4:0]  a1_d,
  output logic [4:0]  a2_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic        we_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic        stall_d,
  output logic        valid_e,
  output logic [31:0] pc_e,
  output logic [31:0] rs1_data_e,
  output logic [31:0] rs2_data_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic        alusrc_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [1:0]  resultsrc_e,
  output logic [2:0]  alucontrol_e
);

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_I    = 7'b0010011;
  localparam logic [6:0]  OP_LW   = 7'b0000011;
  localparam logic [6:0]  OP_SW   = 7'b0100011;
  localparam logic [6:0]  OP_BEQ  = 7'b1100011;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;

  // funct3 to ALU operation; sub only selectable on R-type
  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_op = 3'b000;
    endcase
  endfunction

  logic        dec_valid, dec_regwrite, dec_memwrite, dec_alusrc, dec_branch, dec_jump;
  logic [1:0]  dec_resultsrc;
  logic [2:0]  dec_alucontrol;
  logic [31:0] dec_imm;
  logic        rs1_used, rs2_used, hazard;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic        valid_e_d, valid_e_q;
  logic [31:0] pc_e_d, pc_e_q, rs1_data_e_d, rs1_data_e_q, rs2_data_e_d, rs2_data_e_q;
  logic [31:0] imm_e_d, imm_e_q;
  logic [4:0]  rs1_e_d, rs1_e_q, rs2_e_d, rs2_e_q, rd_e_d, rd_e_q;
  logic        regwrite_e_d, regwrite_e_q, memwrite_e_d, memwrite_e_q;
  logic        alusrc_e_d, alusrc_e_q, branch_e_d, branch_e_q, jump_e_d, jump_e_q;
  logic [1:0]  resultsrc_e_d, resultsrc_e_q;
  logic [2:0]  alucontrol_e_d, alucontrol_e_q;

  assign a1_d  = instr_d[19:15];
  assign a2_d  = instr_d[24:20];

  assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
  assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign imm_j = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

  // x0 always reads zero; a same-cycle writeback overrides the stale register-file read
  assign rs1_val = (a1_d == 5'd0) ? 32'd0 : ((we_w && rd_w == a1_d) ? result_w : rd1_d);
  assign rs2_val = (a2_d == 5'd0) ? 32'd0 : ((we_w && rd_w == a2_d) ? result_w : rd2_d);

  // Opcode decode into controls, immediate and source-use flags; anything else is a bubble
  always_comb begin
    dec_valid      = 1'b0;
    dec_regwrite   = 1'b0;
    dec_memwrite   = 1'b0;
    dec_alusrc     = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_resultsrc  = 2'b00;
    dec_alucontrol = 3'b000;
    dec_imm        = 32'd0;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    if (valid_d && instr_d != NOP_INSTR) begin
      case (instr_d[6:0])
        OP_R: begin
          dec_valid = 1'b1; dec_regwrite = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
          dec_alucontrol = alu_op(instr_d[14:12], instr_d[30]);
        end
        OP_I: begin
          dec_valid = 1'b1; dec_regwrite = 1'b1; dec_alusrc = 1'b1; rs1_used = 1'b1;
          dec_alucontrol = alu_op(instr_d[14:12], 1'b0);
          dec_imm = imm_i;
        end
        OP_LW: begin
          dec_valid = 1'b1; dec_regwrite = 1'b1; dec_alusrc = 1'b1; rs1_used = 1'b1;
          dec_resultsrc = 2'b01;
          dec_imm = imm_i;
        end
        OP_SW: begin
          dec_valid = 1'b1; dec_memwrite = 1'b1; dec_alusrc = 1'b1;
          rs1_used = 1'b1; rs2_used = 1'b1;
          dec_imm = imm_s;
        end
        OP_BEQ: begin
          dec_valid = 1'b1; dec_branch = 1'b1; dec_alucontrol = 3'b001;
          rs1_used = 1'b1; rs2_used = 1'b1;
          dec_imm = imm_b;
        end
        OP_JAL: begin
          dec_valid = 1'b1; dec_regwrite = 1'b1; dec_jump = 1'b1; dec_resultsrc = 2'b10;
          dec_imm = imm_j;
        end
        default: dec_valid = 1'b0;
      endcase
    end
  end

  assign hazard  = valid_e_q && (resultsrc_e_q == 2'b01) && (rd_e_q != 5'd0) &&
                   ((rs1_used && rd_e_q == a1_d) || (rs2_used && rd_e_q == a2_d));
  assign stall_d = hazard && !flush_e;

  // ID/EX next state: bubble on flush, hazard or undecodable input, else the decoded bundle
  always_comb begin
    valid_e_d      = 1'b0;
    pc_e_d         = 32'd0;
    rs1_data_e_d   = 32'd0;
    rs2_data_e_d   = 32'd0;
    imm_e_d        = 32'd0;
    rs1_e_d        = 5'd0;
    rs2_e_d        = 5'd0;
    rd_e_d         = 5'd0;
    regwrite_e_d   = 1'b0;
    memwrite_e_d   = 1'b0;
    alusrc_e_d     = 1'b0;
    branch_e_d     = 1'b0;
    jump_e_d       = 1'b0;
    resultsrc_e_d  = 2'b00;
    alucontrol_e_d = 3'b000;
    if (dec_valid && !flush_e && !hazard) begin
      valid_e_d      = 1'b1;
      pc_e_d         = pc_d;
      rs1_data_e_d   = rs1_val;
      rs2_data_e_d   = rs2_val;
      imm_e_d        = dec_imm;
      rs1_e_d        = a1_d;
      rs2_e_d        = a2_d;
      rd_e_d         = instr_d[11:7];
      regwrite_e_d   = dec_regwrite;
      memwrite_e_d   = dec_memwrite;
      alusrc_e_d     = dec_alusrc;
      branch_e_d     = dec_branch;
      jump_e_d       = dec_jump;
      resultsrc_e_d  = dec_resultsrc;
      alucontrol_e_d = dec_alucontrol;
    end
  end

  // ID/EX pipeline register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e_q      <= 1'b0;
      pc_e_q         <= 32'd0;
      rs1_data_e_q   <= 32'd0;
      rs2_data_e_q   <= 32'd0;
      imm_e_q        <= 32'd0;
      rs1_e_q        <= 5'd0;
      rs2_e_q        <= 5'd0;
      rd_e_q         <= 5'd0;
      regwrite_e_q   <= 1'b0;
      memwrite_e_q   <= 1'b0;
      alusrc_e_q     <= 1'b0;
      branch_e_q     <= 1'b0;
      jump_e_q       <= 1'b0;
      resultsrc_e_q  <= 2'b00;
      alucontrol_e_q <= 3'b000;
    end else begin
      valid_e_q      <= valid_e_d;
      pc_e_q         <= pc_e_d;
      rs1_data_e_q   <= rs1_data_e_d;
      rs2_data_e_q   <= rs2_data_e_d;
      imm_e_q        <= imm_e_d;
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      regwrite_e_q   <= regwrite_e_d;
      memwrite_e_q   <= memwrite_e_d;
      alusrc_e_q     <= alusrc_e_d;
      branch_e_q     <= branch_e_d;
      jump_e_q       <= jump_e_d;
      resultsrc_e_q  <= resultsrc_e_d;
      alucontrol_e_q <= alucontrol_e_d;
    end
  end

  assign valid_e      = valid_e_q;
  assign pc_e         = pc_e_q;
  assign rs1_data_e   = rs1_data_e_q;
  assign rs2_data_e   = rs2_data_e_q;
  assign imm_e        = imm_e_q;
  assign rs1_e        = rs1_e_q;
  assign rs2_e        = rs2_e_q;
  assign rd_e         = rd_e_q;
  assign regwrite_e   = regwrite_e_q;
  assign memwrite_e   = memwrite_e_q;
  assign alusrc_e     = alusrc_e_q;
  assign branch_e     = branch_e_q;
  assign jump_e       = jump_e_q;
  assign resultsrc_e  = resultsrc_e_q;
  assign alucontrol_e = alucontrol_e_q;

endmodule
